// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared control-word layout, opcodes, FSM state and class enums
package riscv_ctrl_pkg;

    localparam int CB_MEM_TO_REG = 0;
    localparam int CB_REG_WRITE  = 1;
    localparam int CB_MEM_WRITE  = 2;
    localparam int CB_MEM_READ   = 3;
    localparam int CB_PC_SRC     = 4;
    localparam int CB_ALU_SRC    = 5;
    localparam int CB_ALU_OP_LO  = 6;
    localparam int CB_ALU_OP_HI  = 7;

    localparam logic [6:0] OP_R_FORMAT = 7'd51;
    localparam logic [6:0] OP_LOAD     = 7'd3;
    localparam logic [6:0] OP_STORE    = 7'd35;
    localparam logic [6:0] OP_BEQ      = 7'd99;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP    = 3'd0,
        CL_RTYPE  = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4
    } instr_class_t;

endpackage

// File: rtl/ctrl_word_classifier.sv
// rtl/ctrl_word_classifier.sv - maps the latched control flags to an instruction class
module ctrl_word_classifier
    import riscv_ctrl_pkg::*;
(
    input  logic [4:0]   flags,
    output instr_class_t cls
);

    always_comb begin
        cls = CL_NOP;
        if (flags[CB_PC_SRC]) begin
            cls = CL_BRANCH;
        end else if (flags[CB_MEM_WRITE]) begin
            cls = CL_STORE;
        end else if (flags[CB_REG_WRITE] && (flags[CB_MEM_TO_REG] || flags[CB_MEM_READ])) begin
            cls = CL_LOAD;
        end else if (flags[CB_REG_WRITE]) begin
            cls = CL_RTYPE;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with cycle and retire counters
module multicycle_sequencer
    import riscv_ctrl_pkg::*;
#(
    parameter int CONTROL_LINE = 8,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CONTROL_LINE-1:0] control,
    input  logic                    alu_zero,
    input  logic                    imem_ready,
    input  logic                    dmem_ready,
    output logic                    imem_req,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    pc_sel,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [1:0]              alu_op,
    output logic                    alu_src,
    output logic                    rf_we,
    output logic                    wb_sel,
    output logic                    retire,
    output logic [2:0]              state,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [CNT_W-1:0]        instr_count
);

    state_t                  state_q, state_d;
    logic [CONTROL_LINE-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]        cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]        instr_count_q, instr_count_d;
    instr_class_t            cls;

    ctrl_word_classifier u_classifier (
        .flags (ctrl_q[CB_PC_SRC:CB_MEM_TO_REG]),
        .cls   (cls)
    );

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        imem_req = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        alu_op   = 2'b00;
        alu_src  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        retire   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ctrl_d  = control;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                alu_op  = ctrl_q[CB_ALU_OP_HI:CB_ALU_OP_LO];
                alu_src = ctrl_q[CB_ALU_SRC];
                case (cls)
                    CL_BRANCH: begin
                        pc_write = alu_zero;
                        pc_sel   = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CL_NOP: begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CL_RTYPE: state_d = ST_WB;
                    default:  state_d = ST_MEM;
                endcase
            end
            ST_MEM: begin
                alu_op   = ctrl_q[CB_ALU_OP_HI:CB_ALU_OP_LO];
                alu_src  = ctrl_q[CB_ALU_SRC];
                dmem_req = 1'b1;
                dmem_we  = (cls == CL_STORE);
                if (dmem_ready) begin
                    if (cls == CL_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                wb_sel  = ctrl_q[CB_MEM_TO_REG];
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
        // Reset must silence every strobe in the same cycle, not just from the next edge.
        if (!rst_n) begin
            imem_req = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
            pc_sel   = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            alu_op   = 2'b00;
            alu_src  = 1'b0;
            rf_we    = 1'b0;
            wb_sel   = 1'b0;
            retire   = 1'b0;
        end
        cycle_count_d = cycle_count_q + CNT_W'(1);
        instr_count_d = instr_count_q + (retire ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            ctrl_q        <= '0;
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = state_q;
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  control = 8'h00;
    logic        alu_zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_write, pc_write, pc_sel, dmem_req, dmem_we;
    logic [1:0]  alu_op;
    logic        alu_src, rf_we, wb_sel, retire;
    logic [2:0]  state;
    logic [31:0] cycle_count, instr_count;

    multicycle_sequencer #(.CONTROL_LINE(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .control(control), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_op(alu_op), .alu_src(alu_src),
        .rf_we(rf_we), .wb_sel(wb_sel), .retire(retire), .state(state),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c;
        int lat, n_dreq, n_dwe, n_rfwe, wbsel, n_pcw, n_pcsel;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    bit   mon_en = 0;
    int   lat, n_ret, mon_cc;
    int   a_irw, a_pcw, a_pcsel, a_dreq, a_dwe, a_rfwe, a_wbsel, a_alubad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference behaviour: what an instruction should look like end to end.
    function automatic exp_t model(input logic [7:0] c, input bit z, input int wi, input int wd);
        exp_t e;
        bit br, st, ld, rt, mem;
        br = c[4];
        st = !br && c[2];
        ld = !br && !st && c[1] && (c[0] || c[3]);
        rt = !br && !st && !ld && c[1];
        mem = ld || st;
        e.c       = c;
        e.lat     = 3 + wi + ((rt || st) ? 1 : 0) + (ld ? 2 : 0) + (mem ? wd : 0);
        e.n_dreq  = mem ? wd + 1 : 0;
        e.n_dwe   = st ? wd + 1 : 0;
        e.n_rfwe  = (ld || rt) ? 1 : 0;
        e.wbsel   = (ld || rt) ? int'(c[0]) : 0;
        e.n_pcw   = 1 + ((br && z) ? 1 : 0);
        e.n_pcsel = br ? 1 : 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            lat++;
            if (ir_write) a_irw++;
            if (pc_write) a_pcw++;
            if (pc_sel)   a_pcsel++;
            if (dmem_req) a_dreq++;
            if (dmem_we)  a_dwe++;
            if (rf_we) begin
                a_rfwe++;
                a_wbsel = int'(wb_sel);
            end
            if (sb.size() > 0) begin
                logic [2:0] want;
                want = (state == 3'd2 || state == 3'd3) ? sb[0].c[7:5] : 3'b000;
                if ({alu_op, alu_src} !== want) a_alubad++;
            end
            if (retire) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire actual=1 expected=0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", lat, e.lat);
                    chk("ir_write_cnt", a_irw, 1);
                    chk("pc_write_cnt", a_pcw, e.n_pcw);
                    chk("pc_sel_cnt", a_pcsel, e.n_pcsel);
                    chk("dmem_req_cnt", a_dreq, e.n_dreq);
                    chk("dmem_we_cnt", a_dwe, e.n_dwe);
                    chk("rf_we_cnt", a_rfwe, e.n_rfwe);
                    chk("wb_sel", a_wbsel, e.wbsel);
                    chk("alu_drive_bad", a_alubad, 0);
                    chk("instr_count", instr_count, n_ret);
                    chk("cycle_count", cycle_count, mon_cc);
                end
                n_ret++;
                lat = 0; a_irw = 0; a_pcw = 0; a_pcsel = 0; a_dreq = 0;
                a_dwe = 0; a_rfwe = 0; a_wbsel = 0; a_alubad = 0;
            end
            mon_cc++;
        end
    end

    task automatic run_instr(input logic [7:0] c, input bit z, input int wi, input int wd);
        int waits, guard;
        sb.push_back(model(c, z, wi, wd));
        control  = c;
        alu_zero = z;
        for (int i = 0; i < wi; i++) begin
            imem_ready = 1'b0;
            @(posedge clk); #1;
        end
        imem_ready = 1'b1;
        @(posedge clk); #1;
        waits = 0;
        guard = 0;
        do begin
            if (guard > 0) control = 8'($urandom);
            imem_ready = 1'($urandom);
            if (dmem_req) begin
                dmem_ready = (waits == wd);
                waits++;
            end else begin
                dmem_ready = 1'($urandom);
            end
            @(posedge clk); #1;
            guard++;
        end while (!imem_req && guard < 30);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        if (guard >= 30) begin
            total++;
            bad++;
            $display("FAIL instr_timeout actual=%0d expected<30", guard);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_retire", retire, 0);
        chk("rst_cycle_count", cycle_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rel_state", state, 0);
        chk("rel_imem_req", imem_req, 1);
        chk("rel_instr_count", instr_count, 0);

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_state", state, 0);
            chk("stall_ir_write", ir_write, 0);
        end
        chk("stall_cycle_count", cycle_count, 5);
        chk("stall_instr_count", instr_count, 0);

        lat = 0; n_ret = 0; mon_cc = 5;
        a_irw = 0; a_pcw = 0; a_pcsel = 0; a_dreq = 0;
        a_dwe = 0; a_rfwe = 0; a_wbsel = 0; a_alubad = 0;
        mon_en = 1;

        run_instr(8'b10_0_0_0_0_1_0, 1'b0, 0, 0);
        run_instr(8'b00_1_0_0_0_1_1, 1'b0, 0, 2);
        run_instr(8'b00_1_0_0_1_0_0, 1'b0, 0, 0);
        run_instr(8'b01_0_1_0_0_0_0, 1'b1, 0, 0);
        run_instr(8'b01_0_1_0_0_0_0, 1'b0, 0, 0);
        run_instr(8'b00_0_0_0_0_0_0, 1'b1, 1, 0);
        for (int i = 0; i < 50; i++) begin
            run_instr(8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        chk("sb_drained", sb.size(), 0);
        mon_en = 0;

        control = 8'b00_1_0_0_0_1_1;
        imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mem_state", state, 3);
        chk("mem_dmem_req", dmem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmem_retire", retire, 0);
        chk("rstmem_rf_we", rf_we, 0);
        chk("rstmem_dmem_we", dmem_we, 0);
        chk("rstmem_dmem_req", dmem_req, 0);
        chk("rstmem_imem_req", imem_req, 0);
        @(posedge clk); #1;
        chk("rstmem_state", state, 0);
        chk("rstmem_cycle_count", cycle_count, 0);
        chk("rstmem_instr_count", instr_count, 0);
        rst_n = 1'b1;
        #1;
        chk("rstmem_rel_imem_req", imem_req, 1);
        @(posedge clk); #1;
        chk("rstmem_rel_cycle_count", cycle_count, 1);
        chk("rstmem_rel_instr_count", instr_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
